// File: rtl/tdm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tdm_pkg
// Shared types and sizes for the 4-slot TDM demultiplexer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package tdm_pkg;
    localparam int SLOT_W    = 2;
    localparam int DATA_W    = 2;
    localparam int NUM_SLOTS = 4;
    localparam int ERRCNT_W  = 8;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage
`default_nettype wire

// File: rtl/tdm_demux_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tdm_demux_if
// Serial TDM input and demultiplexed channel outputs (err_cnt: TDM_DEMUX_ERRCNT_EN).
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface tdm_demux_if;
    import tdm_pkg::*;

    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              sync;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] C;
    logic [DATA_W-1:0] D;
    logic              frame_valid;
    logic [SLOT_W-1:0] slot;
    logic              sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    modport master (
        output din, din_valid, sync,
        input  A, B, C, D, frame_valid, slot, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  din, din_valid, sync,
        output A, B, C, D, frame_valid, slot, sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
        , output err_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tdm_slot_ctr
// Next-expected-slot counter: clear, load-to-1 on frame start, or wrap-increment.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clr_i,
    input  wire logic              load1_i,
    input  wire logic              inc_i,
    output logic [SLOT_W-1:0]      slot_o
);
    logic [SLOT_W-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (load1_i) begin
            slot_q <= SLOT_W'(1);
        end else if (inc_i) begin
            // Natural SLOT_W-bit overflow gives the mod-NUM_SLOTS wrap.
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign slot_o = slot_q;
endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tdm_demux
// 4:1 TDM demultiplexer with HUNT/RUN framing; err_cnt under TDM_DEMUX_ERRCNT_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    tdm_demux_if.slave  bus
);
    state_t              state_q;
    logic [DATA_W-1:0]   shadow_q [0:NUM_SLOTS-2];
    logic [DATA_W-1:0]   out_q    [0:NUM_SLOTS-1];
    logic                frame_valid_q;
    logic                sync_err_q;
    logic [SLOT_W-1:0]   slot;
    logic                ctr_clr;
    logic                ctr_load1;
    logic                ctr_inc;

    // Any sync beat restarts at slot 1; an unsynced beat at slot 0 in RUN drops to HUNT.
    always_comb begin
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;
        if (bus.din_valid) begin
            if (bus.sync) begin
                ctr_load1 = 1'b1;
            end else if (state_q == RUN) begin
                if (slot == '0) ctr_clr = 1'b1;
                else            ctr_inc = 1'b1;
            end
        end
    end

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ctr_clr),
        .load1_i (ctr_load1),
        .inc_i   (ctr_inc),
        .slot_o  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS - 1; i++) shadow_q[i] <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)     out_q[i]    <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (bus.din_valid) begin
                case (state_q)
                    HUNT: begin
                        if (bus.sync) begin
                            shadow_q[0] <= bus.din;
                            state_q     <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.sync) begin
                            shadow_q[0] <= bus.din;
                            sync_err_q  <= (slot != '0);
                        end else if (slot == '0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                        end else begin
                            case (slot)
                                2'd1: shadow_q[1] <= bus.din;
                                2'd2: shadow_q[2] <= bus.din;
                                2'd3: begin
                                    // Last beat bypasses the shadow so the frame lands in one edge.
                                    out_q[0]      <= shadow_q[0];
                                    out_q[1]      <= shadow_q[1];
                                    out_q[2]      <= shadow_q[2];
                                    out_q[3]      <= bus.din;
                                    frame_valid_q <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (sync_err_q && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.A           = out_q[0];
    assign bus.B           = out_q[1];
    assign bus.C           = out_q[2];
    assign bus.D           = out_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.slot        = slot;
    assign bus.sync_err    = sync_err_q;
endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_tdm_demux
// Directed self-checking bench for tdm_demux (err_cnt test under TDM_DEMUX_ERRCNT_EN).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_tdm_demux;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    tdm_demux_if bus ();

    tdm_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat between edges; return just after the capturing edge.
    task automatic beat(input logic [1:0] d, input logic s);
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = 1'b1;
        bus.sync      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.sync      = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 8'h00) begin tests_failed++; $display("FAIL reset_outputs got=%h exp=00", {bus.A, bus.B, bus.C, bus.D}); end
        tests_run++;
        if ({bus.frame_valid, bus.sync_err, bus.slot} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=0000", {bus.frame_valid, bus.sync_err, bus.slot}); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_hunt_discard;
        beat(2'b11, 1'b0);
        beat(2'b10, 1'b0);
        tests_run++;
        if ({bus.slot, bus.sync_err, bus.frame_valid} !== 4'b0000) begin tests_failed++; $display("FAIL hunt_discard got=%b exp=0000", {bus.slot, bus.sync_err, bus.frame_valid}); end
        beat(2'b01, 1'b1);
        tests_run++;
        if (bus.slot !== 2'd1) begin tests_failed++; $display("FAIL hunt_sync_slot got=%0d exp=1", bus.slot); end
        beat(2'b01, 1'b0);
        beat(2'b01, 1'b0);
        beat(2'b01, 1'b0);
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.sync_err} !== 10'b01010101_10) begin tests_failed++; $display("FAIL hunt_frame got=%b exp=0101010110", {bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.sync_err}); end
        idle(1);
    endtask

    task automatic test_basic;
        beat(2'b00, 1'b1);
        beat(2'b01, 1'b0);
        beat(2'b10, 1'b0);
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== 9'b01010101_0) begin tests_failed++; $display("FAIL basic_partial_hidden got=%b exp=010101010", {bus.A, bus.B, bus.C, bus.D, bus.frame_valid}); end
        beat(2'b11, 1'b0);
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 8'b00011011) begin tests_failed++; $display("FAIL basic_data got=%b exp=00011011", {bus.A, bus.B, bus.C, bus.D}); end
        tests_run++;
        if ({bus.frame_valid, bus.sync_err, bus.slot} !== 4'b1000) begin tests_failed++; $display("FAIL basic_flags got=%b exp=1000", {bus.frame_valid, bus.sync_err, bus.slot}); end
        idle(1);
        tests_run++;
        if (bus.frame_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_fv_pulse got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_gaps;
        logic [1:0] data [4];
        int         gap_bad;
        data[0] = 2'b00; data[1] = 2'b01; data[2] = 2'b10; data[3] = 2'b11;
        gap_bad = 0;
        for (int i = 0; i < 4; i++) begin
            beat(data[i], (i == 0));
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    idle(1);
                    if (bus.frame_valid !== 1'b0 || bus.slot !== 2'(i + 1) ||
                        {bus.A, bus.B, bus.C, bus.D} !== 8'b00011011) gap_bad++;
                end
            end
        end
        tests_run++;
        if (gap_bad !== 0) begin tests_failed++; $display("FAIL gaps_stable bad_cycles=%0d exp=0", gap_bad); end
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid} !== 9'b00011011_1) begin tests_failed++; $display("FAIL gaps_frame got=%b exp=000110111", {bus.A, bus.B, bus.C, bus.D, bus.frame_valid}); end
        idle(1);
    endtask

    task automatic test_resync;
        int fv_cnt;
        fv_cnt = 0;
        beat(2'b00, 1'b1); fv_cnt += int'(bus.frame_valid);
        beat(2'b01, 1'b0); fv_cnt += int'(bus.frame_valid);
        beat(2'b11, 1'b1); fv_cnt += int'(bus.frame_valid);
        tests_run++;
        if ({bus.sync_err, bus.slot} !== 3'b101) begin tests_failed++; $display("FAIL resync_err got=%b exp=101", {bus.sync_err, bus.slot}); end
        beat(2'b10, 1'b0); fv_cnt += int'(bus.frame_valid);
        tests_run++;
        if (bus.sync_err !== 1'b0) begin tests_failed++; $display("FAIL resync_err_pulse got=%b exp=0", bus.sync_err); end
        beat(2'b01, 1'b0); fv_cnt += int'(bus.frame_valid);
        beat(2'b00, 1'b0); fv_cnt += int'(bus.frame_valid);
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 8'b11100100) begin tests_failed++; $display("FAIL resync_data got=%b exp=11100100", {bus.A, bus.B, bus.C, bus.D}); end
        idle(1); fv_cnt += int'(bus.frame_valid);
        tests_run++;
        if (fv_cnt !== 1) begin tests_failed++; $display("FAIL resync_fv_count got=%0d exp=1", fv_cnt); end
    endtask

    task automatic test_slot0_nosync;
        beat(2'b10, 1'b1);
        beat(2'b10, 1'b0);
        beat(2'b01, 1'b0);
        beat(2'b01, 1'b0);
        beat(2'b11, 1'b0);
        tests_run++;
        if ({bus.sync_err, bus.slot, bus.frame_valid} !== 4'b1000) begin tests_failed++; $display("FAIL slot0_err got=%b exp=1000", {bus.sync_err, bus.slot, bus.frame_valid}); end
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 8'b10100101) begin tests_failed++; $display("FAIL slot0_hold got=%b exp=10100101", {bus.A, bus.B, bus.C, bus.D}); end
        // In HUNT an unsynced beat is silently dropped: no second error.
        beat(2'b11, 1'b0);
        tests_run++;
        if ({bus.sync_err, bus.slot} !== 3'b000) begin tests_failed++; $display("FAIL slot0_hunt got=%b exp=000", {bus.sync_err, bus.slot}); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [1:0] data [8];
        logic [7:0] fv_seen;
        data[0] = 2'b11; data[1] = 2'b00; data[2] = 2'b01; data[3] = 2'b10;
        data[4] = 2'b10; data[5] = 2'b11; data[6] = 2'b00; data[7] = 2'b01;
        fv_seen = '0;
        for (int i = 0; i < 8; i++) begin
            beat(data[i], (i % 4) == 0);
            fv_seen[i] = bus.frame_valid;
            if (i == 3) begin
                tests_run++;
                if ({bus.A, bus.B, bus.C, bus.D} !== 8'b11000110) begin tests_failed++; $display("FAIL b2b_frame1 got=%b exp=11000110", {bus.A, bus.B, bus.C, bus.D}); end
            end
        end
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D} !== 8'b10110001) begin tests_failed++; $display("FAIL b2b_frame2 got=%b exp=10110001", {bus.A, bus.B, bus.C, bus.D}); end
        tests_run++;
        if (fv_seen !== 8'b1000_1000) begin tests_failed++; $display("FAIL b2b_fv_pattern got=%b exp=10001000", fv_seen); end
    endtask

    task automatic test_reset_midframe;
        int fv_cnt;
        fv_cnt = 0;
        beat(2'b10, 1'b1);
        beat(2'b01, 1'b0);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        rst_n         = 1'b0;
        #1;
        tests_run++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.sync_err, bus.slot} !== 12'h000) begin tests_failed++; $display("FAIL midreset_outputs got=%b exp=000000000000", {bus.A, bus.B, bus.C, bus.D, bus.frame_valid, bus.sync_err, bus.slot}); end
        @(negedge clk);
        rst_n = 1'b1;
        beat(2'b11, 1'b0); fv_cnt += int'(bus.frame_valid);
        beat(2'b00, 1'b0); fv_cnt += int'(bus.frame_valid);
        idle(1);           fv_cnt += int'(bus.frame_valid);
        tests_run++;
        if (fv_cnt !== 0 || bus.slot !== 2'd0) begin tests_failed++; $display("FAIL midreset_no_frame fv=%0d slot=%0d exp fv=0 slot=0", fv_cnt, bus.slot); end
    endtask

`ifdef TDM_DEMUX_ERRCNT_EN
    task automatic test_err_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 300; e++) begin
            beat(2'b00, 1'b1);
            beat(2'b01, 1'b0);
            beat(2'b10, 1'b0);
            beat(2'b11, 1'b0);
            beat(2'b00, 1'b0);
            if (e == 0) begin
                idle(1);
                tests_run++;
                if (bus.err_cnt !== 8'd1) begin tests_failed++; $display("FAIL errcnt_first got=%0d exp=1", bus.err_cnt); end
            end
        end
        idle(2);
        tests_run++;
        if (bus.err_cnt !== 8'hFF) begin tests_failed++; $display("FAIL errcnt_sat got=%h exp=ff", bus.err_cnt); end
    endtask
`endif

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.din       = 2'b00;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_hunt_discard();
        test_basic();
        test_gaps();
        test_resync();
        test_slot0_nosync();
        test_back_to_back();
        test_reset_midframe();
`ifdef TDM_DEMUX_ERRCNT_EN
        test_err_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 din  input  2  serial TDM slot data, the output stream of the 4:1 mux.
REQ-005 din_valid  input  1  din carries a slot beat this cycle.
REQ-006 sync  input  1  frame marker; meaningful only when din_valid=1; marks the slot-0 beat.
REQ-007 A, B, C, D  output  2 each  registered channel values for slots 0..3.
REQ-008 frame_valid  output  1  one-cycle pulse; A..D were updated with a complete frame.
REQ-009 slot  output  2  next expected slot index.
REQ-010 sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 err_cnt  output  8  saturating framing-error count; present only with TDM_DEMUX_ERRCNT_EN.

Function
REQ-012 The FSM SHALL have two states: HUNT and RUN.
REQ-013 HUNT: beats without sync SHALL be discarded; a beat with sync SHALL be stored as slot 0, set slot=1, and enter RUN.
REQ-014 RUN: each valid beat SHALL be stored into shadow register slot[slot], and slot SHALL increment mod 4.
REQ-015 Cycles with din_valid=0 SHALL hold slot, the shadow registers and the outputs unchanged.
REQ-016 On the slot-3 beat (cycle N), A..D SHALL load shadow0..2 and the current din together at edge N+1; frame_valid SHALL be 1 for exactly that one cycle, giving a latency of 1 cycle.
REQ-017 A..D SHALL change only on frame completion; partial frames SHALL never reach the outputs.
REQ-018 A sync beat in RUN with slot!=0: pulse sync_err, discard the partial frame, store the beat as slot 0, set slot=1, stay in RUN.
REQ-019 A valid beat in RUN with slot==0 and sync=0: pulse sync_err, discard the beat, set slot=0, enter HUNT.
REQ-020 A sync beat in RUN with slot==0 is a normal frame start with no error.
REQ-021 Back-to-back frames with no idle cycles SHALL produce a frame_valid every 4 beats.
REQ-022 sync with din_valid=0 SHALL be ignored.

Reset
REQ-023 While rst_n=0: state=HUNT, slot=0, shadow=0, A=B=C=D=2'b00, frame_valid=0, sync_err=0, err_cnt=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame immediately; the first frame after release SHALL require a sync beat.

Configuration
REQ-025 Macro TDM_DEMUX_ERRCNT_EN defined: err_cnt SHALL increment by 1 on each sync_err pulse and saturate at 8'hFF.
REQ-026 Macro TDM_DEMUX_ERRCNT_EN undefined: the err_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 A shared package tdm_pkg SHALL hold the state typedef (HUNT, RUN), SLOT_W=2, DATA_W=2, NUM_SLOTS=4 and ERRCNT_W=8.
REQ-028 The slot counter with its wrap and load-to-1 logic SHALL be one sub-module, tdm_slot_ctr; everything else SHALL stay in tdm_demux.

Verification
REQ-029 Frame sync+00, 01, 10, 11 on consecutive cycles -> one cycle after the last beat: A=00, B=01, C=10, D=11, frame_valid=1 for 1 cycle, sync_err=0.
REQ-030 Same frame with din_valid=0 gaps of 2 cycles between beats -> identical outputs; frame_valid one cycle after the 4th beat; outputs stable during the gaps.
REQ-031 Beats 11, 10 without sync after reset -> discarded; then frame 01, 01, 01, 01 starting with sync -> A..D=01, no sync_err.
REQ-032 Beats sync+00, 01, then sync+11, 10, 01, 00 -> sync_err pulse on the 3rd beat; A=11, B=10, C=01, D=00; exactly one frame_valid.
REQ-033 One complete frame, then a beat at slot 0 without sync -> sync_err pulse, state HUNT, A..D hold the prior frame; with TDM_DEMUX_ERRCNT_EN, 300 such errors -> err_cnt=8'hFF.
REQ-034 rst_n pulsed low after 2 beats of a frame -> all outputs 0; the remaining 2 beats produce no frame_valid.
